// File: rtl/chimp_seq_ctrl.sv
// chimp_seq_ctrl: level/number/strike sequencing for the chimp memory test.
// Moore FSM plus registered counters; outputs decode registered state only.
module chimp_seq_ctrl #(
  parameter int NUM_W = 5,
  parameter int MAX_LEVEL = 31,
  parameter int START_LEVEL = 4,
  parameter int STRIKES = 3,
  localparam int SW = $clog2(STRIKES + 1)
) (
  input  logic             clk,
  input  logic             iResetn,
  input  logic             iSpace,
  input  logic             iDoneLoad,
  input  logic             iChoseCorrectNum,
  input  logic             iChoseWrongNum,
  output logic [NUM_W-1:0] oLevel,
  output logic [NUM_W-1:0] oNumToChoose,
  output logic             oLoadEnable,
  output logic             oShowEnable,
  output logic             oResetBoard,
  output logic [SW-1:0]    oStrikes,
  output logic [NUM_W-1:0] oBestLevel,
  output logic             oLevelPass,
  output logic             oGameOver
);
  typedef enum logic [2:0] {IDLE, LOAD, CHOOSE, PASS, FAIL, OVER} state_t;
  state_t state, next;
  logic space_q, space_ev, ok, bad, last;
  logic [NUM_W-1:0] level, num, best;
  logic [SW-1:0] strikes;
  assign space_ev = space_q & ~iSpace;
  // a wrong click in the same cycle as a correct one takes priority
  assign bad  = (state == CHOOSE) & iChoseWrongNum;
  assign ok   = (state == CHOOSE) & iChoseCorrectNum & ~iChoseWrongNum;
  assign last = num == level;
  always_ff @(posedge clk or negedge iResetn)
    if (!iResetn) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE, PASS, FAIL, OVER: next = space_ev ? LOAD : state;
      LOAD: next = iDoneLoad ? CHOOSE : LOAD;
      CHOOSE:
        if (bad) next = (strikes + SW'(1) == SW'(STRIKES)) ? OVER : FAIL;
        else if (ok && last) next = (level == NUM_W'(MAX_LEVEL)) ? OVER : PASS;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge iResetn)
    if (!iResetn) begin
      space_q <= 1'b0;
      level   <= NUM_W'(START_LEVEL);
      num     <= '0;
      strikes <= '0;
      best    <= '0;
    end else begin
      space_q <= iSpace;
      if (state == IDLE || (state == OVER && space_ev)) begin
        level   <= NUM_W'(START_LEVEL);
        strikes <= '0;
      end
      if (state == LOAD && iDoneLoad) num <= NUM_W'(1);
      if (ok && !last) num <= num + NUM_W'(1);
      if (ok && last && level != NUM_W'(MAX_LEVEL)) level <= level + NUM_W'(1);
      if (ok && last && level > best) best <= level;
      if (bad && strikes != SW'(STRIKES)) strikes <= strikes + SW'(1);
    end
  always_comb begin
    oLevel       = level;
    oNumToChoose = (state == CHOOSE) ? num : '0;
    oLoadEnable  = state == LOAD;
    oShowEnable  = (state == LOAD) | ((state == CHOOSE) & (num == NUM_W'(1)));
    oResetBoard  = state inside {IDLE, PASS, FAIL, OVER};
    oStrikes     = strikes;
    oBestLevel   = best;
    oLevelPass   = state == PASS;
    oGameOver    = state == OVER;
  end
endmodule
